mem_access_unit: RTL and testbench

- Parametrised memory-access pipeline stage sitting between EX and WB.
- Accepts one EX result per handshake and issues loads and stores on a split request/response data bus (req/addr_ok, then data_ok); the bus may have multi-cycle latency.
- Aligns and sign- or zero-extends load data, builds store strobes and lane-replicated store data, and flags misaligned addresses.
- Delivers the result to WB through a valid/ready handshake, replacing the fixed single-cycle SRAM MEM stage.

---
 rtl/mem_pkg.sv | 49 ++++
 rtl/mem_align.sv | 72 +++++++
 rtl/mem_access_unit.sv | 164 ++++++++++++++++
 tb/tb_mem_access_unit.sv | 363 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared types and helpers for the memory-access stage.
package mem_pkg;

  typedef enum logic [3:0] {
    NONE = 4'd0,
    LB   = 4'd1,
    LBU  = 4'd2,
    LH   = 4'd3,
    LHU  = 4'd4,
    LW   = 4'd5,
    LWU  = 4'd6,
    LD   = 4'd7,
    SB   = 4'd8,
    SH   = 4'd9,
    SW   = 4'd10,
    SD   = 4'd11
  } mem_op_t;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_REQ   = 3'd1,
    ST_WAIT  = 3'd2,
    ST_DONE  = 3'd3,
    ST_DRAIN = 3'd4
  } state_t;

  function automatic logic is_load(mem_op_t op);
    return op inside {LB, LBU, LH, LHU, LW, LWU, LD};
  endfunction

  function automatic logic is_store(mem_op_t op);
    return op inside {SB, SH, SW, SD};
  endfunction

  // log2 of the access size in bytes
  function automatic logic [1:0] op_size(mem_op_t op);
    case (op)
      LH, LHU, SH:  return 2'd1;
      LW, LWU, SW:  return 2'd2;
      LD, SD:       return 2'd3;
      default:      return 2'd0;
    endcase
  endfunction

  function automatic logic op_signed(mem_op_t op);
    return op inside {LB, LH, LW, LD};
  endfunction

endpackage

// File: rtl/mem_align.sv
// Combinational lane logic: alignment check, store strobes and data
// replication, and load byte extraction with sign/zero extension.
module mem_align
  import mem_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int LANE_W = $clog2(DATA_W/8)
) (
  input  mem_op_t             op,
  input  logic [2:0]          addr_lo,
  input  logic [DATA_W-1:0]   wdata,
  output logic                misaligned,
  output logic [1:0]          size,
  output logic [DATA_W/8-1:0] wstrb,
  output logic [DATA_W-1:0]   wdata_rep,
  input  mem_op_t             ld_op,
  input  logic [LANE_W-1:0]   ld_lane,
  input  logic [DATA_W-1:0]   rdata,
  output logic [DATA_W-1:0]   ld_data
);

  localparam int STRB_W = DATA_W/8;

  logic [STRB_W-1:0] base_strb;
  logic [1:0]        ld_size;
  logic [DATA_W-1:0] shifted;
  logic [DATA_W-1:0] keep;
  logic              sbit;
  int                nbytes;
  int                nbits;

  // Natural alignment: the low log2(bytes) address bits must be zero
  always_comb begin
    size       = op_size(op);
    misaligned = 1'b0;
    if (is_load(op) || is_store(op)) begin
      case (size)
        2'd1:    misaligned = addr_lo[0];
        2'd2:    misaligned = |addr_lo[1:0];
        2'd3:    misaligned = |addr_lo;
        default: misaligned = 1'b0;
      endcase
    end
  end

  // Strobes cover the accessed bytes at the lane; data is replicated so
  // every lane carries the right-aligned store bytes
  always_comb begin
    nbytes    = 1 << size;
    base_strb = '0;
    for (int i = 0; i < STRB_W; i++) base_strb[i] = (i < nbytes);
    wstrb     = base_strb << addr_lo[LANE_W-1:0];
    wdata_rep = '0;
    for (int i = 0; i < STRB_W; i++) wdata_rep[8*i +: 8] = wdata[8*(i % nbytes) +: 8];
  end

  // Shift the addressed lane down, keep the access bytes, extend the rest
  always_comb begin
    ld_size = op_size(ld_op);
    shifted = rdata >> {ld_lane, 3'b000};
    nbits   = 8 << ld_size;
    keep    = '0;
    for (int i = 0; i < DATA_W; i++) keep[i] = (i < nbits);
    case (ld_size)
      2'd0:    sbit = shifted[7];
      2'd1:    sbit = shifted[15];
      default: sbit = shifted[31];
    endcase
    ld_data = (shifted & keep) | ((op_signed(ld_op) && sbit) ? ~keep : '0);
  end

endmodule

// File: rtl/mem_access_unit.sv
// Memory-access pipeline stage between EX and WB: accepts one EX result,
// runs a split request/response bus transaction for loads and stores, and
// hands the result to WB through a valid/ready handshake.
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int LANE_W = $clog2(DATA_W/8)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [31:0]         in_pc,
  input  mem_op_t             in_op,
  input  logic [ADDR_W-1:0]   in_addr,
  input  logic [DATA_W-1:0]   in_wdata,
  input  logic                in_rf_we,
  input  logic [4:0]          in_rf_waddr,
  input  logic [DATA_W-1:0]   in_ex_result,
  output logic                bus_req,
  output logic                bus_wr,
  output logic [1:0]          bus_size,
  output logic [DATA_W/8-1:0] bus_wstrb,
  output logic [ADDR_W-1:0]   bus_addr,
  output logic [DATA_W-1:0]   bus_wdata,
  input  logic                bus_addr_ok,
  input  logic                bus_data_ok,
  input  logic [DATA_W-1:0]   bus_rdata,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [31:0]         out_pc,
  output logic                out_rf_we,
  output logic [4:0]          out_rf_waddr,
  output logic [DATA_W-1:0]   out_rf_wdata,
  output logic                out_exc_adel,
  output logic                out_exc_ades,
  output logic [ADDR_W-1:0]   out_badvaddr,
  output logic                busy
);

  localparam int STRB_W = DATA_W/8;

  state_t            state, state_nx, accept_target;
  mem_op_t           op_q;
  logic              accept;
  logic              is_mem;
  logic              mis;
  logic [1:0]        a_size;
  logic [STRB_W-1:0] a_wstrb;
  logic [DATA_W-1:0] a_wdata;
  logic [DATA_W-1:0] ld_data;

  mem_align #(
    .DATA_W (DATA_W),
    .LANE_W (LANE_W)
  ) u_align (
    .op         (in_op),
    .addr_lo    (in_addr[2:0]),
    .wdata      (in_wdata),
    .misaligned (mis),
    .size       (a_size),
    .wstrb      (a_wstrb),
    .wdata_rep  (a_wdata),
    .ld_op      (op_q),
    .ld_lane    (bus_addr[LANE_W-1:0]),
    .rdata      (bus_rdata),
    .ld_data    (ld_data)
  );

  // Handshake and status outputs decoded from the current state
  always_comb begin
    in_ready  = (state == ST_IDLE) || (state == ST_DONE && out_ready);
    accept    = in_valid && in_ready && !flush;
    is_mem    = is_load(in_op) || is_store(in_op);
    bus_req   = (state == ST_REQ);
    out_valid = (state == ST_DONE);
    busy      = (state == ST_REQ) || (state == ST_WAIT) || (state == ST_DRAIN);
  end

  // Next state; flush wins over accept, and a flushed bus transaction that
  // already had its address accepted must still drain its response
  always_comb begin
    state_nx      = state;
    accept_target = (!is_mem || mis) ? ST_DONE : ST_REQ;
    case (state)
      ST_IDLE: begin
        if (accept) state_nx = accept_target;
      end
      ST_REQ: begin
        if (flush)            state_nx = bus_addr_ok ? ST_DRAIN : ST_IDLE;
        else if (bus_addr_ok) state_nx = ST_WAIT;
      end
      ST_WAIT: begin
        if (bus_data_ok) state_nx = flush ? ST_IDLE : ST_DONE;
        else if (flush)  state_nx = ST_DRAIN;
      end
      ST_DONE: begin
        if (flush)          state_nx = ST_IDLE;
        else if (out_ready) state_nx = accept ? accept_target : ST_IDLE;
      end
      ST_DRAIN: begin
        if (bus_data_ok) state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nx;
  end

  // Latch the instruction on accept, hold the bus request and WB result
  // stable, and capture extracted load data when the response arrives
  always_ff @(posedge clk) begin
    if (rst) begin
      op_q         <= NONE;
      bus_wr       <= 1'b0;
      bus_size     <= 2'd0;
      bus_wstrb    <= '0;
      bus_addr     <= '0;
      bus_wdata    <= '0;
      out_pc       <= '0;
      out_rf_we    <= 1'b0;
      out_rf_waddr <= '0;
      out_rf_wdata <= '0;
      out_exc_adel <= 1'b0;
      out_exc_ades <= 1'b0;
      out_badvaddr <= '0;
    end else if (accept) begin
      op_q         <= in_op;
      out_pc       <= in_pc;
      out_rf_waddr <= in_rf_waddr;
      out_exc_adel <= 1'b0;
      out_exc_ades <= 1'b0;
      out_badvaddr <= '0;
      if (!is_mem) begin
        out_rf_we    <= in_rf_we;
        out_rf_wdata <= in_ex_result;
      end else if (mis) begin
        out_rf_we    <= 1'b0;
        out_rf_wdata <= '0;
        out_exc_adel <= is_load(in_op);
        out_exc_ades <= is_store(in_op);
        out_badvaddr <= in_addr;
      end else begin
        out_rf_we    <= in_rf_we;
        out_rf_wdata <= in_ex_result;
        bus_addr     <= in_addr;
        bus_wr       <= is_store(in_op);
        bus_size     <= a_size;
        bus_wstrb    <= is_store(in_op) ? a_wstrb : '0;
        bus_wdata    <= a_wdata;
      end
    end else if (state == ST_WAIT && bus_data_ok && !flush && is_load(op_q)) begin
      out_rf_wdata <= ld_data;
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench: 32-bit and 64-bit instances, directed vectors, and a
// monitor per instance comparing every WB handshake against the queue.
module tb_mem_access_unit;
  import mem_pkg::*;

  typedef struct {
    logic [31:0] pc;
    logic        we;
    logic [4:0]  waddr;
    logic [63:0] wdata;
    logic        chk_wdata;
    logic        adel;
    logic        ades;
    logic [31:0] bad;
  } exp_t;

  logic clk, rst, flush, out_ready;
  logic v32, v64;
  logic rdy32, rdy64;
  logic [31:0] in_pc, in_addr;
  mem_op_t     in_op;
  logic [63:0] in_wdata, in_ex, rdata;
  logic        in_we;
  logic [4:0]  in_waddr;
  logic        addr_ok, data_ok;

  logic        bus_req32, bus_wr32, out_valid32, out_we32, adel32, ades32, busy32;
  logic [1:0]  bus_size32;
  logic [3:0]  bus_wstrb32;
  logic [31:0] bus_addr32, bus_wdata32, out_pc32, out_wdata32, bad32;
  logic [4:0]  out_waddr32;

  logic        bus_req64, bus_wr64, out_valid64, out_we64, adel64, ades64, busy64;
  logic [1:0]  bus_size64;
  logic [7:0]  bus_wstrb64;
  logic [31:0] bus_addr64, out_pc64, bad64;
  logic [63:0] bus_wdata64, out_wdata64;
  logic [4:0]  out_waddr64;

  exp_t sb32[$];
  exp_t sb64[$];
  int   asserts = 0;
  int   fails   = 0;
  int   w;

  mem_access_unit #(.DATA_W(32), .ADDR_W(32)) dut32 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(v32), .in_ready(rdy32),
    .in_pc(in_pc), .in_op(in_op), .in_addr(in_addr), .in_wdata(in_wdata[31:0]),
    .in_rf_we(in_we), .in_rf_waddr(in_waddr), .in_ex_result(in_ex[31:0]),
    .bus_req(bus_req32), .bus_wr(bus_wr32), .bus_size(bus_size32), .bus_wstrb(bus_wstrb32),
    .bus_addr(bus_addr32), .bus_wdata(bus_wdata32), .bus_addr_ok(addr_ok),
    .bus_data_ok(data_ok), .bus_rdata(rdata[31:0]), .out_valid(out_valid32),
    .out_ready(out_ready), .out_pc(out_pc32), .out_rf_we(out_we32),
    .out_rf_waddr(out_waddr32), .out_rf_wdata(out_wdata32), .out_exc_adel(adel32),
    .out_exc_ades(ades32), .out_badvaddr(bad32), .busy(busy32)
  );

  mem_access_unit #(.DATA_W(64), .ADDR_W(32)) dut64 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(v64), .in_ready(rdy64),
    .in_pc(in_pc), .in_op(in_op), .in_addr(in_addr), .in_wdata(in_wdata),
    .in_rf_we(in_we), .in_rf_waddr(in_waddr), .in_ex_result(in_ex),
    .bus_req(bus_req64), .bus_wr(bus_wr64), .bus_size(bus_size64), .bus_wstrb(bus_wstrb64),
    .bus_addr(bus_addr64), .bus_wdata(bus_wdata64), .bus_addr_ok(addr_ok),
    .bus_data_ok(data_ok), .bus_rdata(rdata), .out_valid(out_valid64),
    .out_ready(out_ready), .out_pc(out_pc64), .out_rf_we(out_we64),
    .out_rf_waddr(out_waddr64), .out_rf_wdata(out_wdata64), .out_exc_adel(adel64),
    .out_exc_ades(ades64), .out_badvaddr(bad64), .busy(busy64)
  );

  // Free-running clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case something wedges the run
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    asserts++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic timeoutFail(input string name);
    asserts++;
    fails++;
    $display("[TB] FAIL %s: got timeout, expected DUT response", name);
  endtask

  function automatic exp_t mkExp(input logic [31:0] pc, input logic we, input logic [4:0] wa,
                                 input logic [63:0] wd, input logic chk, input logic adel,
                                 input logic ades, input logic [31:0] bad);
    exp_t e;
    e.pc = pc; e.we = we; e.waddr = wa; e.wdata = wd; e.chk_wdata = chk;
    e.adel = adel; e.ades = ades; e.bad = bad;
    return e;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic idleInputs();
    v32 = 1'b0;
    v64 = 1'b0;
    in_op = NONE;
  endtask

  // Present one instruction and hold it until accepted; the expected WB
  // result is queued on the accepting edge when track is set
  task automatic applyStimulus(input bit wide, input logic [31:0] pc, input mem_op_t op,
                               input logic [31:0] addr, input logic [63:0] wdata,
                               input logic [63:0] ex, input logic we, input logic [4:0] wa,
                               input exp_t e, input bit track, output int waited);
    in_pc = pc; in_op = op; in_addr = addr; in_wdata = wdata; in_ex = ex;
    in_we = we; in_waddr = wa;
    if (wide) v64 = 1'b1; else v32 = 1'b1;
    waited = 0;
    @(negedge clk);
    while (!(wide ? rdy64 : rdy32) && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (waited >= 50) timeoutFail("accept_timeout");
    @(posedge clk);
    if (track) begin
      if (wide) sb64.push_back(e); else sb32.push_back(e);
    end
    #1;
  endtask

  // Answer the outstanding request after the given address/data delays
  task automatic busRespond(input bit wide, input int okDelay, input int dataDelay,
                            input logic [63:0] rd);
    int n;
    n = 0;
    while (!(wide ? bus_req64 : bus_req32) && n < 20) begin
      tick(1);
      n++;
    end
    if (n >= 20) timeoutFail("bus_req_timeout");
    tick(okDelay);
    addr_ok = 1'b1;
    tick(1);
    addr_ok = 1'b0;
    tick(dataDelay);
    data_ok = 1'b1;
    rdata = rd;
    tick(1);
    data_ok = 1'b0;
  endtask

  // Monitor for the 32-bit instance
  always @(negedge clk) begin
    if (!rst && out_valid32 && out_ready) begin
      if (sb32.size() == 0) begin
        timeoutFail("unexpected_out32");
      end else begin
        exp_t e;
        e = sb32.pop_front();
        checkOutput("out_pc32", {32'h0, out_pc32}, {32'h0, e.pc});
        checkOutput("out_rf_we32", {63'h0, out_we32}, {63'h0, e.we});
        checkOutput("out_rf_waddr32", {59'h0, out_waddr32}, {59'h0, e.waddr});
        if (e.chk_wdata) checkOutput("out_rf_wdata32", {32'h0, out_wdata32}, {32'h0, e.wdata[31:0]});
        checkOutput("out_exc_adel32", {63'h0, adel32}, {63'h0, e.adel});
        checkOutput("out_exc_ades32", {63'h0, ades32}, {63'h0, e.ades});
        checkOutput("out_badvaddr32", {32'h0, bad32}, {32'h0, e.bad});
      end
    end
  end

  // Monitor for the 64-bit instance
  always @(negedge clk) begin
    if (!rst && out_valid64 && out_ready) begin
      if (sb64.size() == 0) begin
        timeoutFail("unexpected_out64");
      end else begin
        exp_t e;
        e = sb64.pop_front();
        checkOutput("out_pc64", {32'h0, out_pc64}, {32'h0, e.pc});
        checkOutput("out_rf_we64", {63'h0, out_we64}, {63'h0, e.we});
        checkOutput("out_rf_waddr64", {59'h0, out_waddr64}, {59'h0, e.waddr});
        if (e.chk_wdata) checkOutput("out_rf_wdata64", out_wdata64, e.wdata);
        checkOutput("out_exc_adel64", {63'h0, adel64}, {63'h0, e.adel});
        checkOutput("out_exc_ades64", {63'h0, ades64}, {63'h0, e.ades});
        checkOutput("out_badvaddr64", {32'h0, bad64}, {32'h0, e.bad});
      end
    end
  end

  initial begin
    rst = 1'b1; flush = 1'b0; out_ready = 1'b1; v32 = 1'b0; v64 = 1'b0;
    in_op = NONE; in_pc = '0; in_addr = '0; in_wdata = '0; in_ex = '0;
    in_we = 1'b0; in_waddr = '0; addr_ok = 1'b0; data_ok = 1'b0; rdata = '0;
    tick(3);
    $display("[TB] reset checks");
    checkOutput("rst_out_valid32", {63'h0, out_valid32}, 64'h0);
    checkOutput("rst_bus_req32", {63'h0, bus_req32}, 64'h0);
    checkOutput("rst_busy32", {63'h0, busy32}, 64'h0);
    checkOutput("rst_adel32", {63'h0, adel32}, 64'h0);
    checkOutput("rst_wdata32", {32'h0, out_wdata32}, 64'h0);
    checkOutput("rst_wstrb32", {60'h0, bus_wstrb32}, 64'h0);
    checkOutput("rst_out_valid64", {63'h0, out_valid64}, 64'h0);
    checkOutput("rst_bus_req64", {63'h0, bus_req64}, 64'h0);
    rst = 1'b0;
    tick(1);

    $display("[TB] 32-bit loads");
    applyStimulus(0, 32'h100, LB, 32'h1003, 64'h0, 64'h0, 1'b1, 5'd3,
                  mkExp(32'h100, 1, 5'd3, 64'hFFFFFF80, 1, 0, 0, 0), 1, w);
    idleInputs();
    busRespond(0, 1, 2, 64'h80AABBCC);
    tick(2);
    applyStimulus(0, 32'h104, LBU, 32'h1003, 64'h0, 64'h0, 1'b1, 5'd4,
                  mkExp(32'h104, 1, 5'd4, 64'h00000080, 1, 0, 0, 0), 1, w);
    idleInputs();
    busRespond(0, 0, 0, 64'h80AABBCC);
    tick(2);
    applyStimulus(0, 32'h108, LH, 32'h2002, 64'h0, 64'h0, 1'b1, 5'd5,
                  mkExp(32'h108, 1, 5'd5, 64'h00007FFF, 1, 0, 0, 0), 1, w);
    idleInputs();
    busRespond(0, 0, 1, 64'h7FFF1234);
    tick(2);

    $display("[TB] misaligned accesses");
    out_ready = 1'b0;
    applyStimulus(0, 32'h10C, LH, 32'h2001, 64'h0, 64'h0, 1'b1, 5'd6,
                  mkExp(32'h10C, 0, 5'd6, 64'h0, 0, 1, 0, 32'h2001), 1, w);
    idleInputs();
    checkOutput("adel_no_req", {63'h0, bus_req32}, 64'h0);
    checkOutput("adel_not_busy", {63'h0, busy32}, 64'h0);
    checkOutput("adel_valid", {63'h0, out_valid32}, 64'h1);
    out_ready = 1'b1;
    tick(2);
    applyStimulus(0, 32'h110, SW, 32'h3002, 64'h12345678, 64'h0, 1'b0, 5'd0,
                  mkExp(32'h110, 0, 5'd0, 64'h0, 0, 0, 1, 32'h3002), 1, w);
    idleInputs();
    checkOutput("ades_no_req", {63'h0, bus_req32}, 64'h0);
    tick(2);

    $display("[TB] store with held-off addr_ok");
    applyStimulus(0, 32'h200, SB, 32'h3001, 64'h000000A5, 64'h0, 1'b0, 5'd0,
                  mkExp(32'h200, 0, 5'd0, 64'h0, 0, 0, 0, 0), 1, w);
    idleInputs();
    for (int i = 0; i < 3; i++) begin
      checkOutput("sb_req", {63'h0, bus_req32}, 64'h1);
      checkOutput("sb_wr", {63'h0, bus_wr32}, 64'h1);
      checkOutput("sb_wstrb", {60'h0, bus_wstrb32}, 64'h2);
      checkOutput("sb_wdata", {32'h0, bus_wdata32}, 64'hA5A5A5A5);
      checkOutput("sb_size", {62'h0, bus_size32}, 64'h0);
      checkOutput("sb_addr", {32'h0, bus_addr32}, 64'h3001);
      tick(1);
    end
    busRespond(0, 0, 0, 64'h0);
    tick(2);

    $display("[TB] back-to-back ALU ops");
    for (int k = 0; k < 4; k++) begin
      applyStimulus(0, 32'h700 + 32'(4*k), NONE, 32'h0, 64'h0, 64'h11111111 * 64'(k+1),
                    1'b1, 5'(k+1),
                    mkExp(32'h700 + 32'(4*k), 1, 5'(k+1), 64'h11111111 * 64'(k+1), 1, 0, 0, 0),
                    1, w);
      checkOutput("b2b_no_wait", 64'(w), 64'h0);
    end
    idleInputs();
    tick(2);

    $display("[TB] WB stall holds outputs");
    out_ready = 1'b0;
    applyStimulus(0, 32'h600, NONE, 32'h0, 64'h0, 64'h12345678, 1'b1, 5'd7,
                  mkExp(32'h600, 1, 5'd7, 64'h12345678, 1, 0, 0, 0), 1, w);
    idleInputs();
    for (int i = 0; i < 2; i++) begin
      checkOutput("stall_valid", {63'h0, out_valid32}, 64'h1);
      checkOutput("stall_wdata", {32'h0, out_wdata32}, 64'h12345678);
      checkOutput("stall_pc", {32'h0, out_pc32}, 64'h600);
      checkOutput("stall_in_ready", {63'h0, rdy32}, 64'h0);
      tick(1);
    end
    out_ready = 1'b1;
    tick(2);

    $display("[TB] flush in WAIT drains the response");
    applyStimulus(0, 32'h800, LW, 32'h5000, 64'h0, 64'h0, 1'b1, 5'd9,
                  mkExp(32'h800, 1, 5'd9, 64'h0, 0, 0, 0, 0), 0, w);
    idleInputs();
    addr_ok = 1'b1;
    tick(1);
    addr_ok = 1'b0;
    flush = 1'b1;
    tick(1);
    flush = 1'b0;
    in_op = NONE; in_pc = 32'h900; in_ex = 64'hCAFEF00D; in_we = 1'b1; in_waddr = 5'd10;
    v32 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      checkOutput("drain_busy", {63'h0, busy32}, 64'h1);
      checkOutput("drain_in_ready", {63'h0, rdy32}, 64'h0);
      checkOutput("drain_no_valid", {63'h0, out_valid32}, 64'h0);
      if (i == 3) begin
        data_ok = 1'b1;
        rdata = 64'hDEADBEEF;
      end
      tick(1);
    end
    data_ok = 1'b0;
    checkOutput("drain_exit_ready", {63'h0, rdy32}, 64'h1);
    checkOutput("drain_exit_idle", {63'h0, busy32}, 64'h0);
    applyStimulus(0, 32'h900, NONE, 32'h0, 64'h0, 64'hCAFEF00D, 1'b1, 5'd10,
                  mkExp(32'h900, 1, 5'd10, 64'hCAFEF00D, 1, 0, 0, 0), 1, w);
    idleInputs();
    tick(2);

    $display("[TB] 64-bit accesses");
    applyStimulus(1, 32'hA00, LD, 32'h4008, 64'h0, 64'h0, 1'b1, 5'd11,
                  mkExp(32'hA00, 1, 5'd11, 64'h8000000000000001, 1, 0, 0, 0), 1, w);
    idleInputs();
    busRespond(1, 0, 1, 64'h8000000000000001);
    tick(2);
    applyStimulus(1, 32'hA04, LWU, 32'h400C, 64'h0, 64'h0, 1'b1, 5'd12,
                  mkExp(32'hA04, 1, 5'd12, 64'h0000000080000000, 1, 0, 0, 0), 1, w);
    idleInputs();
    busRespond(1, 0, 0, 64'h8000000000000001);
    tick(2);
    applyStimulus(1, 32'hA08, LW, 32'h400C, 64'h0, 64'h0, 1'b1, 5'd13,
                  mkExp(32'hA08, 1, 5'd13, 64'hFFFFFFFF80000000, 1, 0, 0, 0), 1, w);
    idleInputs();
    busRespond(1, 0, 0, 64'h8000000000000001);
    tick(2);
    applyStimulus(1, 32'hA0C, SH, 32'h4006, 64'h000000000000BEEF, 64'h0, 1'b0, 5'd0,
                  mkExp(32'hA0C, 0, 5'd0, 64'h0, 0, 0, 0, 0), 1, w);
    idleInputs();
    checkOutput("sh64_wstrb", {56'h0, bus_wstrb64}, 64'hC0);
    checkOutput("sh64_wdata", bus_wdata64, 64'hBEEFBEEFBEEFBEEF);
    checkOutput("sh64_size", {62'h0, bus_size64}, 64'h1);
    busRespond(1, 0, 0, 64'h0);
    tick(2);

    $display("[TB] reset during REQ");
    applyStimulus(1, 32'hB00, LD, 32'h4010, 64'h0, 64'h0, 1'b1, 5'd14,
                  mkExp(32'hB00, 1, 5'd14, 64'h0, 0, 0, 0, 0), 0, w);
    idleInputs();
    checkOutput("rstreq_req_before", {63'h0, bus_req64}, 64'h1);
    rst = 1'b1;
    tick(1);
    checkOutput("rstreq_req_after", {63'h0, bus_req64}, 64'h0);
    checkOutput("rstreq_busy_after", {63'h0, busy64}, 64'h0);
    checkOutput("rstreq_valid_after", {63'h0, out_valid64}, 64'h0);
    rst = 1'b0;
    tick(3);

    checkOutput("sb32_drained", 64'(sb32.size()), 64'h0);
    checkOutput("sb64_drained", 64'(sb64.size()), 64'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
    $finish;
  end

endmodule
